inc_arbiter_2to1: RTL and testbench
===================================

Name: inc_arbiter_2to1

Overview:
- Shares one registered WIDTH-bit increment datapath (data + INC) between two independent requesters.
- Each requester (e.g. the two FIFO read sides) presents operands over a valid/ready handshake.
- A round-robin arbiter grants one operand per cycle; the incremented result returns on a single response channel tagged with the requester id.
- Sits between the two FIFOs and the downstream consumer. It is the sole owner of the increment resource.

Parameters:
- WIDTH, 8, operand/result width in bits (legal 1..32)
- INC, 1, increment constant added to each operand; must satisfy 0 <= INC < 2^WIDTH

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset; deassertion synchronised externally
- req0_valid  in  1  requester 0 operand valid
- req0_ready  out  1  requester 0 operand accepted this cycle
- req0_data  in  WIDTH  requester 0 operand
- req1_valid  in  1  requester 1 operand valid
- req1_ready  out  1  requester 1 operand accepted this cycle
- req1_data  in  WIDTH  requester 1 operand
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  WIDTH  (operand + INC) mod 2^WIDTH
- rsp_id  out  1  requester that issued this result
- rsp_ovf  out  1  carry-out of the addition

Behaviour:
- Reset (async, rst_n=0): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, state=EMPTY, last_grant=1. Consequence: requester 0 wins the first contention.
- reqN_ready reset value: reqN_ready is combinational and is 0 while rst_n=0.
- States:
  - EMPTY: no result held.
  - FULL: result held, rsp_valid=1.
- can_accept = (state==EMPTY) || rsp_ready.
- Grant, combinational:
  - Only one valid: that one is granted.
  - Both valid: the requester != last_grant is granted.
  - reqN_ready = can_accept && grant==N. At most one ready is high per cycle.
- Accept: on reqN_valid && reqN_ready, at the next edge:
  - {rsp_ovf, rsp_data} <= req_data + INC, computed at WIDTH+1 bits.
  - rsp_id <= N, last_grant <= N, state <= FULL.
- Latency: 1 cycle from accept to rsp_valid.
- Throughput: 1 result per cycle while rsp_ready=1.
- FULL && rsp_ready && no accept -> EMPTY, rsp_valid=0. Data outputs hold their last value.
- FULL && !rsp_ready: result outputs stable, no ready asserted. Backpressure is held without loss or change.
- Simultaneous response drain and new accept in one cycle: the new result replaces the old one; state stays FULL.
- Valid requirement: a requester must not drop valid or change data until it is accepted. The block neither checks nor relies on this.
- last_grant updates only on an actual accept, never on a bare valid.
- Overflow: operand 2^WIDTH-1 with INC=1 -> rsp_data=0, rsp_ovf=1.
- Reset mid-operation: a held result is discarded, the pointer returns to last_grant=1, and no response is emitted.

Optional Feature:
- Macro: INC_ARB_STATS_EN.
- Defined:
  - Adds output ports grant_cnt0 and grant_cnt1, 16 bits each.
  - Each counts accepts for its requester and saturates at 0xFFFF.
  - Both reset to 0 asynchronously.
- Undefined: ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package inc_arb_pkg holds:
  - state enum {EMPTY, FULL}
  - requester id type (1 bit)
  - stats counter width constant (16)
- Sub-module rr_arb2: two-input round-robin grant logic.
  - Inputs: valid0, valid1, last_grant, enable.
  - Outputs: one-hot grant.
  - Purely combinational; the last_grant register stays in the parent.

Test Plan:
- Reset, then req0_valid=1 with data 0x05, rsp_ready=1 -> req0_ready=1 the same cycle; next cycle rsp_valid=1, rsp_data=0x06, rsp_id=0, rsp_ovf=0.
- Both valid continuously (data0=0x10, data1=0x20), rsp_ready=1 -> responses alternate id 0,1,0,1 with data 0x11,0x21, one per cycle, starting with id 0.
- Response held with rsp_ready=0 for 5 cycles while both request -> both readys 0, and rsp_data/rsp_id stay constant. Raising rsp_ready -> next accept occurs the same cycle.
- req1 data 0xFF, WIDTH=8, INC=1 -> rsp_data=0x00, rsp_ovf=1, rsp_id=1.
- rst_n asserted while FULL with rsp_ready=0 -> rsp_valid=0 immediately (asynchronous). After release with both valid -> req0 granted first.
- INC_ARB_STATS_EN defined: 3 accepts from req0 and 2 from req1 -> grant_cnt0=3, grant_cnt1=2. Force 0xFFFF and accept again -> count stays 0xFFFF.

Source files
------------

// File: rtl/inc_arbiter_2to1_pkg.sv
// Shared types and constants for the 2:1 increment arbiter.
// Read by inc_arbiter_2to1 and rr_arb2.
package inc_arb_pkg;

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    typedef logic req_id_t;

    localparam int unsigned StatsCntW = 16;

    // Saturating increment for the optional grant counters.
    function automatic logic [StatsCntW-1:0] sat_inc(input logic [StatsCntW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/inc_arbiter_2to1_if.sv
// Request/response bundle for inc_arbiter_2to1: two operand channels in, one tagged result out.
// slave is the arbiter side, master is the requester/consumer side.
interface inc_arbiter_2to1_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_ovf;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
    );
endinterface

// File: rtl/inc_arbiter_2to1_rr_arb2.sv
// Two-input round-robin grant, purely combinational; the pointer register lives in the parent.
// On contention the requester that was not granted last wins.
module rr_arb2
    import inc_arb_pkg::*;
(
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  req_id_t    last_grant_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            unique case ({valid1_i, valid0_i})
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/inc_arbiter_2to1.sv
// Shares one registered (operand + INC) datapath between two requesters, round-robin arbitrated.
// Optional per-requester saturating grant counters when INC_ARB_STATS_EN is defined.
module inc_arbiter_2to1
    import inc_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned INC   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inc_arbiter_2to1_if.slave    bus
`ifdef INC_ARB_STATS_EN
    ,
    output logic [StatsCntW-1:0] grant_cnt0,
    output logic [StatsCntW-1:0] grant_cnt1
`endif
);

    localparam logic [WIDTH:0] IncExt = (WIDTH+1)'(INC);

    state_e           state_q, state_d;
    req_id_t          last_grant_q, last_grant_d;
    req_id_t          id_q, id_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;

    logic             can_accept;
    logic [1:0]       grant;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH:0]   sum;

    // Ready is forced low while reset is held, independent of the state register.
    assign can_accept = rst_n && ((state_q == StEmpty) || bus.rsp_ready);

    rr_arb2 u_rr_arb2 (
        .valid0_i     (bus.req0_valid),
        .valid1_i     (bus.req1_valid),
        .last_grant_i (last_grant_q),
        .enable_i     (can_accept),
        .grant_o      (grant)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    assign accept   = (grant[0] && bus.req0_valid) || (grant[1] && bus.req1_valid);
    assign sel_data = grant[1] ? bus.req1_data : bus.req0_data;
    assign sum      = {1'b0, sel_data} + IncExt;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        data_d       = data_q;
        ovf_d        = ovf_q;
        if (accept) begin
            {ovf_d, data_d} = sum;
            id_d            = grant[1];
            last_grant_d    = grant[1];
            state_d         = StFull;
        end else if ((state_q == StFull) && bus.rsp_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            data_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            data_q       <= data_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.rsp_valid = (state_q == StFull);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_ovf   = ovf_q;

`ifdef INC_ARB_STATS_EN
    logic [StatsCntW-1:0] stats_cnt0_q, stats_cnt0_d;
    logic [StatsCntW-1:0] stats_cnt1_q, stats_cnt1_d;

    always_comb begin
        stats_cnt0_d = stats_cnt0_q;
        stats_cnt1_d = stats_cnt1_q;
        if (grant[0] && bus.req0_valid) stats_cnt0_d = sat_inc(stats_cnt0_q);
        if (grant[1] && bus.req1_valid) stats_cnt1_d = sat_inc(stats_cnt1_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stats_cnt0_q <= '0;
            stats_cnt1_q <= '0;
        end else begin
            stats_cnt0_q <= stats_cnt0_d;
            stats_cnt1_q <= stats_cnt1_d;
        end
    end

    assign grant_cnt0 = stats_cnt0_q;
    assign grant_cnt1 = stats_cnt1_q;
`endif

endmodule

// File: tb/tb_inc_arbiter_2to1.sv
// Directed + random bench for inc_arbiter_2to1 with a reference arbiter model and result scoreboard.
// Covers the grant counters too when INC_ARB_STATS_EN is defined.
module tb_inc_arbiter_2to1;
    import inc_arb_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned INC   = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    inc_arbiter_2to1_if #(.WIDTH(WIDTH)) bus ();

`ifdef INC_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    inc_arbiter_2to1 #(
        .WIDTH (WIDTH),
        .INC   (INC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef INC_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] data;
        logic             ovf;
    } rsp_t;

    rsp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic m_last      = 1'b1;
    int   m_cnt0      = 0;
    int   m_cnt1      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t model_inc(input logic id, input logic [WIDTH-1:0] d);
        rsp_t              r;
        logic [63:0]       s;
        s      = 64'(d) + 64'(INC);
        r.id   = id;
        r.data = s[WIDTH-1:0];
        r.ovf  = s[WIDTH];
        return r;
    endfunction

    task automatic drive(input logic v0, input logic [WIDTH-1:0] d0,
                         input logic v1, input logic [WIDTH-1:0] d1, input logic rr);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.rsp_ready  = rr;
    endtask

    // One clock: check at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        logic full, can, g0, g1;
        rsp_t e;
        @(negedge clk);
        full = (exp_q.size() != 0);
        can  = !full || bus.rsp_ready;
        g0   = can && bus.req0_valid && (!bus.req1_valid || m_last);
        g1   = can && bus.req1_valid && (!bus.req0_valid || !m_last);
        chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(full));
`ifdef INC_ARB_STATS_EN
        chk("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
        chk("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
`endif
        if (full) begin
            e = exp_q[0];
            chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            chk("rsp_ovf", 32'(bus.rsp_ovf), 32'(e.ovf));
            if (bus.rsp_ready) void'(exp_q.pop_front());
        end
        if (g0) begin
            exp_q.push_back(model_inc(1'b0, bus.req0_data));
            m_last = 1'b0;
            if (m_cnt0 < 'hFFFF) m_cnt0++;
        end
        if (g1) begin
            exp_q.push_back(model_inc(1'b1, bus.req1_data));
            m_last = 1'b1;
            if (m_cnt1 < 'hFFFF) m_cnt1++;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle (no clock edge before the checks), then release after the next edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_ovf", 32'(bus.rsp_ovf), 32'd0);
        exp_q.delete();
        m_last = 1'b1;
        m_cnt0 = 0;
        m_cnt1 = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        apply_reset();

        // Single request, one-cycle latency
        drive(1'b1, 8'h05, 1'b0, 8'h00, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle();

        // Continuous contention alternates, starting with requester 0
        apply_reset();
        drive(1'b1, 8'h10, 1'b1, 8'h20, 1'b1);
        repeat (8) cycle();

        // Backpressure: result held, no ready, pointer untouched
        bus.rsp_ready = 1'b0;
        repeat (5) cycle();
        bus.rsp_ready = 1'b1;
        repeat (2) cycle();

        // Overflow on requester 1
        drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (2) cycle();

        // Reset while a result is held under backpressure
        drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
        cycle();
        bus.req0_valid = 1'b0;
        cycle();
        apply_reset();
        drive(1'b1, 8'h44, 1'b1, 8'h55, 1'b1);
        repeat (4) cycle();

        // Random traffic
        repeat (60) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  8'($urandom), 1'($urandom_range(0, 3) != 0));
            cycle();
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (2) cycle();

`ifdef INC_ARB_STATS_EN
        apply_reset();
        drive(1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
        repeat (3) cycle();
        drive(1'b0, 8'h00, 1'b1, 8'h02, 1'b1);
        repeat (2) cycle();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle();
        chk("grant_cnt0_3", 32'(grant_cnt0), 32'd3);
        chk("grant_cnt1_2", 32'(grant_cnt1), 32'd2);
        force dut.stats_cnt0_q = 16'hFFFF;
        #1;
        release dut.stats_cnt0_q;
        m_cnt0 = 'hFFFF;
        drive(1'b1, 8'h07, 1'b0, 8'h00, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle();
        chk("grant_cnt0_sat", 32'(grant_cnt0), 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
